// File: rtl/player_jump_sequencer_pkg.sv
// Shared definitions for the frame-rate player blocks: jump FSM encoding,
// game-state and PS/2 scan-code constants.
package jump_pkg;

  localparam int DATA_W = 10;

  typedef enum logic [1:0] {
    GROUND = 2'b00,
    RISE   = 2'b01,
    APEX   = 2'b10,
    FALL   = 2'b11
  } jump_state_e;

  localparam logic [1:0] PLAY_STATE = 2'b01;

  // Scan codes shared with the horizontal movement block
  localparam logic [7:0] KEY_W     = 8'h1D;
  localparam logic [7:0] KEY_A     = 8'h1C;
  localparam logic [7:0] KEY_S     = 8'h1B;
  localparam logic [7:0] KEY_D     = 8'h23;
  localparam logic [7:0] KEY_SPACE = 8'h29;
  localparam logic [7:0] JUMP_KEY  = KEY_W;

  function automatic logic is_jump_key(input logic press, input logic [7:0] code);
    return press && (code == JUMP_KEY);
  endfunction

endpackage

// File: rtl/player_jump_sequencer_if.sv
// Key/game inputs and per-frame vertical motion outputs of the jump sequencer.
interface player_jump_sequencer_if;
  import jump_pkg::*;

  logic        [7:0]        keycode;
  logic                     keyPress;
  logic        [1:0]        gameState;
  logic        [DATA_W-1:0] PlayerY;
  logic signed [DATA_W-1:0] YMotion;
  logic                     YUpdate;
  logic                     Airborne;
  logic        [1:0]        JumpState;

  modport master (
    output keycode, keyPress, gameState, PlayerY,
    input  YMotion, YUpdate, Airborne, JumpState
  );

  modport slave (
    input  keycode, keyPress, gameState, PlayerY,
    output YMotion, YUpdate, Airborne, JumpState
  );

endinterface

// File: rtl/player_jump_sequencer_vsync_tick.sv
// Brings VS into the Clk domain and emits a one-cycle frame_tick per VS rise;
// the tick register is set on the third Clk edge that sees VS high.
module vsync_tick (
  input  logic Clk,
  input  logic Reset_n,
  input  logic VS,
  output logic frame_tick
);

  logic vs_meta_p0;
  logic vs_sync_p1;
  logic vs_prev_p2;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      vs_meta_p0 <= 1'b0;
      vs_sync_p1 <= 1'b0;
      vs_prev_p2 <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      // p0/p1: two-flop synchronizer; p2: previous synchronized level
      vs_meta_p0 <= VS;
      vs_sync_p1 <= vs_meta_p0;
      vs_prev_p2 <= vs_sync_p1;
      frame_tick <= vs_sync_p1 & ~vs_prev_p2;
    end
  end

endmodule

// File: rtl/player_jump_sequencer.sv
// Per-frame vertical motion sequencer: ground, rise, apex hold, fall, landing.
// Issues a signed Y displacement with a one-cycle YUpdate once per frame_tick.
module player_jump_sequencer
  import jump_pkg::*;
#(
  parameter logic [3:0]        V0          = 4'd8,
  parameter logic [3:0]        GRAVITY     = 4'd1,
  parameter logic [2:0]        APEX_FRAMES = 3'd2,
  parameter logic [3:0]        MAX_FALL    = 4'd8,
  parameter logic [DATA_W-1:0] GROUND_Y    = 10'd168
) (
  input logic Clk,
  input logic Reset_n,
  input logic VS,
  player_jump_sequencer_if.slave bus
);

  function automatic logic signed [DATA_W-1:0] pos_speed(input logic [3:0] s);
    return $signed({{(DATA_W-4){1'b0}}, s});
  endfunction

  function automatic logic signed [DATA_W-1:0] neg_speed(input logic [3:0] s);
    return -$signed({{(DATA_W-4){1'b0}}, s});
  endfunction

  function automatic logic [3:0] sat_fall_speed(input logic [3:0] s);
    logic [4:0] sum;
    sum = {1'b0, s} + {1'b0, GRAVITY};
    return (sum > {1'b0, MAX_FALL}) ? MAX_FALL : sum[3:0];
  endfunction

  // Final step onto the ground; a player already at or below it moves by 0
  function automatic logic signed [DATA_W-1:0] land_step(input logic [DATA_W-1:0] y);
    logic [DATA_W-1:0] diff;
    diff = GROUND_Y - y;
    return (y >= GROUND_Y) ? '0 : $signed(diff);
  endfunction

  logic                     frame_tick;
  logic [1:0]               game_state_p0;
  logic [1:0]               game_state_p1;
  logic                     play_p1;
  logic                     key_term;
  logic                     key_prev_p0;
  logic                     key_rise;
  logic                     jump_req_q;
  logic                     req_consume;
  logic                     req_clr;
  jump_state_e              state_q;
  jump_state_e              state_nx;
  logic [3:0]               speed_q;
  logic [3:0]               speed_nx;
  logic [2:0]               apex_cnt_q;
  logic [2:0]               apex_cnt_nx;
  logic signed [DATA_W-1:0] ymot_q;
  logic signed [DATA_W-1:0] ymot_nx;
  logic                     yupd_q;
  logic [DATA_W:0]          land_sum;
  logic                     landing;

  vsync_tick u_vsync_tick (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .VS         (VS),
    .frame_tick (frame_tick)
  );

  assign key_term = is_jump_key(bus.keyPress, bus.keycode);
  assign key_rise = key_term & ~key_prev_p0;
  assign play_p1  = (game_state_p1 == PLAY_STATE);

  // 11-bit sum so a PlayerY near the top of the range cannot wrap past ground
  assign land_sum = {1'b0, bus.PlayerY} + {{(DATA_W-3){1'b0}}, speed_q};
  assign landing  = (land_sum >= {1'b0, GROUND_Y});

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      game_state_p0 <= 2'b00;
      game_state_p1 <= 2'b00;
      key_prev_p0   <= 1'b0;
      jump_req_q    <= 1'b0;
    end else begin
      // p0/p1: game state registered twice before use
      game_state_p0 <= bus.gameState;
      game_state_p1 <= game_state_p0;
      key_prev_p0   <= key_term;
      // A fresh key edge wins over a same-cycle clear so it is seen next frame
      if (key_rise) begin
        jump_req_q <= 1'b1;
      end else if (req_clr) begin
        jump_req_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q    <= GROUND;
      speed_q    <= 4'd0;
      apex_cnt_q <= 3'd0;
      ymot_q     <= '0;
      yupd_q     <= 1'b0;
    end else begin
      state_q    <= state_nx;
      speed_q    <= speed_nx;
      apex_cnt_q <= apex_cnt_nx;
      ymot_q     <= ymot_nx;
      yupd_q     <= frame_tick;
    end
  end

  always_comb begin
    state_nx    = state_q;
    speed_nx    = speed_q;
    apex_cnt_nx = apex_cnt_q;
    ymot_nx     = ymot_q;
    req_consume = 1'b0;
    if (frame_tick) begin
      if (!play_p1) begin
        state_nx    = GROUND;
        speed_nx    = 4'd0;
        apex_cnt_nx = 3'd0;
        ymot_nx     = '0;
      end else begin
        unique case (state_q)
          GROUND: begin
            if (jump_req_q) begin
              ymot_nx     = neg_speed(V0);
              speed_nx    = V0 - GRAVITY;
              state_nx    = RISE;
              req_consume = 1'b1;
            end else begin
              ymot_nx = '0;
            end
          end
          RISE: begin
            ymot_nx = neg_speed(speed_q);
            if (speed_q <= GRAVITY) begin
              speed_nx    = 4'd0;
              apex_cnt_nx = APEX_FRAMES;
              state_nx    = APEX;
            end else begin
              speed_nx = speed_q - GRAVITY;
            end
          end
          APEX: begin
            ymot_nx = '0;
            if (apex_cnt_q <= 3'd1) begin
              apex_cnt_nx = 3'd0;
              speed_nx    = GRAVITY;
              state_nx    = FALL;
            end else begin
              apex_cnt_nx = apex_cnt_q - 3'd1;
            end
          end
          FALL: begin
            if (landing) begin
              ymot_nx  = land_step(bus.PlayerY);
              speed_nx = 4'd0;
              state_nx = GROUND;
            end else begin
              ymot_nx  = pos_speed(speed_q);
              speed_nx = sat_fall_speed(speed_q);
            end
          end
        endcase
      end
    end
    req_clr = frame_tick && (req_consume || (state_q != GROUND) || !play_p1);
  end

  assign bus.YMotion   = ymot_q;
  assign bus.YUpdate   = yupd_q;
  assign bus.Airborne  = (state_q != GROUND);
  assign bus.JumpState = state_q;

endmodule

// File: tb/tb_player_jump_sequencer.sv
// Directed bench for player_jump_sequencer with a frame-level trajectory model.
module tb_player_jump_sequencer;

  logic Clk     = 1'b0;
  logic Reset_n = 1'b0;
  logic VS      = 1'b0;

  player_jump_sequencer_if bus ();

  player_jump_sequencer dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .VS      (VS),
    .bus     (bus.slave)
  );

  always #5 Clk = ~Clk;

  localparam int PH_GROUND = 0, PH_RISE = 1, PH_APEX = 2, PH_FALL = 3;
  localparam int G_Y = 168;

  int checks = 0;
  int errors = 0;

  // Model state: VS / gameState sample history, request, trajectory queue
  int vh [0:4];
  int gh [0:2];
  bit kprev, m_req;
  int m_phase, m_spd;
  int q_mot[$];
  int q_ph[$];
  int e_y, e_upd;

  int py_req = 0, py_ack = 0, py_val = 0;
  int upd_count = 0;
  int mot_log[$];

  int exp_jump [19] = '{-8, -7, -6, -5, -4, -3, -2, -1, 0, 0,
                        1, 2, 3, 4, 5, 6, 7, 8, 0};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One frame of the vertical motion rules
  task automatic model_frame();
    int y;
    int v;
    y = int'(bus.PlayerY);
    if (gh[2] != 1) begin
      q_mot.delete(); q_ph.delete();
      m_phase = PH_GROUND; m_spd = 0; e_y = 0; m_req = 0;
    end else if (m_phase == PH_GROUND && !m_req) begin
      e_y = 0;
    end else begin
      if (m_phase == PH_GROUND) begin
        v = 8;
        q_mot.push_back(-v); q_ph.push_back(PH_RISE);
        v = v - 1;
        forever begin
          q_mot.push_back(-v); q_ph.push_back(v <= 1 ? PH_APEX : PH_RISE);
          if (v <= 1) break;
          v = v - 1;
        end
        for (int i = 1; i <= 2; i++) begin
          q_mot.push_back(0); q_ph.push_back(i == 2 ? PH_FALL : PH_APEX);
        end
      end
      m_req = 0;
      if (q_mot.size() > 0) begin
        e_y = q_mot.pop_front();
        m_phase = q_ph.pop_front();
        if (m_phase == PH_FALL) m_spd = 1;
      end else if (y + m_spd >= G_Y) begin
        e_y = (y >= G_Y) ? 0 : G_Y - y;
        m_phase = PH_GROUND;
      end else begin
        e_y = m_spd;
        m_spd = (m_spd + 1 > 8) ? 8 : m_spd + 1;
      end
    end
  endtask

  always @(posedge Clk) begin
    bit term;
    #1;
    if (!Reset_n) begin
      for (int k = 0; k < 5; k++) vh[k] = 0;
      for (int k = 0; k < 3; k++) gh[k] = 0;
      kprev = 0; m_req = 0; m_phase = PH_GROUND; m_spd = 0;
      q_mot.delete(); q_ph.delete();
      e_y = 0; e_upd = 0;
    end else begin
      for (int k = 4; k > 0; k--) vh[k] = vh[k-1];
      vh[0] = int'(VS);
      gh[2] = gh[1]; gh[1] = gh[0]; gh[0] = int'(bus.gameState);
      if (vh[3] == 1 && vh[4] == 0) begin
        e_upd = 1;
        model_frame();
      end else begin
        e_upd = 0;
      end
      term = bus.keyPress && (bus.keycode == 8'h1D);
      if (term && !kprev) m_req = 1;
      kprev = term;
    end
    check("ymotion",   int'(bus.YMotion),   e_y);
    check("yupdate",   int'(bus.YUpdate),   e_upd);
    check("airborne",  int'(bus.Airborne),  (m_phase != PH_GROUND) ? 1 : 0);
    check("jumpstate", int'(bus.JumpState), m_phase);
    if (bus.YUpdate) begin
      upd_count++;
      mot_log.push_back(int'(bus.YMotion));
      bus.PlayerY = bus.PlayerY + bus.YMotion;
    end
    if (py_req != py_ack) begin
      bus.PlayerY = py_val[9:0];
      py_ack = py_req;
    end
  end

  task automatic vs_pulse(input int width);
    @(negedge Clk); VS = 1'b1;
    repeat (width) @(negedge Clk);
    VS = 1'b0;
    repeat (8) @(negedge Clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) vs_pulse(2);
  endtask

  task automatic key_tap();
    @(negedge Clk); bus.keyPress = 1'b1; bus.keycode = 8'h1D;
    @(negedge Clk); bus.keyPress = 1'b0;
    repeat (2) @(negedge Clk);
  endtask

  task automatic set_py(input int v);
    @(negedge Clk); py_val = v; py_req++;
    repeat (2) @(negedge Clk);
  endtask

  function automatic int last_mot();
    return (mot_log.size() > 0) ? mot_log[mot_log.size()-1] : 9999;
  endfunction

  initial begin
    int u0, lg, cnt;
    bus.keycode = 8'h00; bus.keyPress = 1'b0; bus.gameState = 2'b01;
    py_val = G_Y; py_req = 1;
    Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    check("reset_ymotion",   int'(bus.YMotion),   0);
    check("reset_yupdate",   int'(bus.YUpdate),   0);
    check("reset_airborne",  int'(bus.Airborne),  0);
    check("reset_jumpstate", int'(bus.JumpState), 0);
    Reset_n = 1'b1;
    repeat (4) @(negedge Clk);

    // Idle frames with no key
    u0 = upd_count;
    frames(5);
    check("idle_updates", upd_count - u0, 5);
    check("idle_ymotion", last_mot(), 0);

    // Edge count from VS sampled high to the YUpdate cycle
    @(negedge Clk); VS = 1'b1; cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk); #2; cnt++;
      if (bus.YUpdate) break;
    end
    check("update_latency", cnt, 4);
    @(negedge Clk); VS = 1'b0;
    repeat (8) @(negedge Clk);

    // Full jump from the ground
    lg = mot_log.size();
    key_tap();
    frames(19);
    check("jump_frames", mot_log.size() - lg, 19);
    for (int i = 0; i < 19; i++)
      if (lg + i < mot_log.size()) check("jump_step", mot_log[lg+i], exp_jump[i]);
    check("jump_land_y", int'(bus.PlayerY), G_Y);
    check("jump_land_state", int'(bus.JumpState), 0);

    // Key held across the landing gives a single jump
    lg = mot_log.size();
    @(negedge Clk); bus.keyPress = 1'b1; bus.keycode = 8'h1D;
    frames(22);
    check("held_first", (lg < mot_log.size()) ? mot_log[lg] : 9999, -8);
    for (int i = 18; i < 22; i++)
      if (lg + i < mot_log.size()) check("held_no_rejump", mot_log[lg+i], 0);
    check("held_state", int'(bus.JumpState), 0);
    @(negedge Clk); bus.keyPress = 1'b0;
    frames(1);
    @(negedge Clk); bus.keyPress = 1'b1;
    frames(1);
    check("repress_jump", last_mot(), -8);
    check("repress_state", int'(bus.JumpState), 1);
    @(negedge Clk); bus.keyPress = 1'b0;

    // Leaving play during RISE
    frames(2);
    check("rise_before_exit", last_mot(), -6);
    @(negedge Clk); bus.gameState = 2'b10;
    frames(1);
    check("exit_ymotion", last_mot(), 0);
    check("exit_state", int'(bus.JumpState), 0);
    check("exit_airborne", int'(bus.Airborne), 0);
    @(negedge Clk); bus.gameState = 2'b01;
    frames(2);
    check("exit_stays_ground", last_mot(), 0);

    // Landing clamp from PlayerY 165 with fall speed 8
    set_py(G_Y);
    key_tap();
    frames(17);
    check("fall_speed7", last_mot(), 7);
    check("fall_y", int'(bus.PlayerY), 160);
    set_py(165);
    frames(1);
    check("clamp_step", last_mot(), 3);
    check("clamp_state", int'(bus.JumpState), 0);
    check("clamp_y", int'(bus.PlayerY), G_Y);

    // Reset during FALL
    key_tap();
    frames(14);
    check("pre_reset_state", int'(bus.JumpState), 3);
    @(negedge Clk); Reset_n = 1'b0;
    @(posedge Clk); #2;
    check("rst_ymotion",   int'(bus.YMotion),   0);
    check("rst_yupdate",   int'(bus.YUpdate),   0);
    check("rst_airborne",  int'(bus.Airborne),  0);
    check("rst_jumpstate", int'(bus.JumpState), 0);
    @(negedge Clk);
    @(negedge Clk); Reset_n = 1'b1;
    set_py(G_Y);
    repeat (4) @(negedge Clk);

    // Single-cycle VS pulse
    u0 = upd_count;
    @(negedge Clk); VS = 1'b1;
    @(negedge Clk); VS = 1'b0;
    repeat (12) @(negedge Clk);
    check("short_vs_updates", upd_count - u0, 1);
    check("short_vs_ymotion", int'(bus.YMotion), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
